// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM. Moore outputs decoded from the current state,
// with mem_ready gating the FETCH IR/PC writes and the MEMWR completion pulse.
// Sequences lw, sw, R-type, beq, addi and j; other opcodes are flagged and skipped.
module multicycle_controller #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRd    = 4'd3,
    StMemWb    = 4'd4,
    StMemWr    = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiExec = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  state_e state_q;
  logic   rdy;
  logic   op_legal;

  // With waits disabled every memory access completes in a single cycle.
  assign rdy   = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state = state_q;

  // Flag opcodes this core does not implement.
  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OpRtype, OpLw, OpSw, OpBeq, OpAddi, OpJ: op_legal = 1'b1;
      default:                                 op_legal = 1'b0;
    endcase
  end

  // State register and next-state sequencing; reset aborts any instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFetch;
    end else begin
      case (state_q)
        StFetch:    if (rdy) state_q <= StDecode;
        StDecode: begin
          case (opcode)
            OpLw, OpSw: state_q <= StMemAdr;
            OpRtype:    state_q <= StExecute;
            OpBeq:      state_q <= StBranch;
            OpAddi:     state_q <= StAddiExec;
            OpJ:        state_q <= StJump;
            default:    state_q <= StFetch;
          endcase
        end
        StMemAdr:   state_q <= (opcode == OpLw) ? StMemRd : StMemWr;
        StMemRd:    if (rdy) state_q <= StMemWb;
        StMemWr:    if (rdy) state_q <= StFetch;
        StExecute:  state_q <= StAluWb;
        StAddiExec: state_q <= StAddiWb;
        StMemWb, StAluWb, StAddiWb, StBranch, StJump: state_q <= StFetch;
        default:    state_q <= StFetch;
      endcase
    end
  end

  // Datapath controls decoded from state; unlisted controls stay 0.
  always_comb begin
    memread    = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      StFetch: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        // IR and PC only update on the cycle the read completes.
        irwrite = rdy;
        pcwrite = rdy;
      end
      StDecode: begin
        alusrcb = 2'b11;
        illegal = ~op_legal;
      end
      StMemAdr, StAddiExec: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StMemRd: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      StMemWb: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
      end
      StMemWr: begin
        memwrite   = 1'b1;
        iord       = 1'b1;
        instr_done = rdy;
      end
      StExecute: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      StAluWb: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        instr_done = 1'b1;
      end
      StBranch: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      StAddiWb: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      StJump: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: builds an expected per-cycle trace for each
// instruction from its class and stall counts, then plays it against the DUT.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       memread, memwrite, iord, irwrite, pcwrite, branch;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb, aluop;
  logic       regdst, memtoreg, regwrite, instr_done, illegal;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_controller #(.MEM_WAIT_EN(1'b1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .memread   (memread),
    .memwrite  (memwrite),
    .iord      (iord),
    .irwrite   (irwrite),
    .pcwrite   (pcwrite),
    .branch    (branch),
    .pcsrc     (pcsrc),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .aluop     (aluop),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .regwrite  (regwrite),
    .instr_done(instr_done),
    .illegal   (illegal),
    .state     (state)
  );

  always #5 clk = ~clk;

  logic [17:0] outv;
  assign outv = {memread, memwrite, iord, irwrite, pcwrite, branch, pcsrc, alusrca, alusrcb,
                 aluop, regdst, memtoreg, regwrite, instr_done, illegal};

  // Control bit masks in outv order.
  localparam logic [17:0] MR   = 18'h20000;
  localparam logic [17:0] MW   = 18'h10000;
  localparam logic [17:0] IORD = 18'h08000;
  localparam logic [17:0] IRW  = 18'h04000;
  localparam logic [17:0] PCW  = 18'h02000;
  localparam logic [17:0] BR   = 18'h01000;
  localparam logic [17:0] PC10 = 18'h00800;
  localparam logic [17:0] PC01 = 18'h00400;
  localparam logic [17:0] SA   = 18'h00200;
  localparam logic [17:0] SB10 = 18'h00100;
  localparam logic [17:0] SB01 = 18'h00080;
  localparam logic [17:0] SB11 = 18'h00180;
  localparam logic [17:0] AO10 = 18'h00040;
  localparam logic [17:0] AO01 = 18'h00020;
  localparam logic [17:0] RD   = 18'h00010;
  localparam logic [17:0] MTR  = 18'h00008;
  localparam logic [17:0] RW   = 18'h00004;
  localparam logic [17:0] DONE = 18'h00002;
  localparam logic [17:0] ILL  = 18'h00001;

  typedef struct {
    logic [3:0]  st;
    logic [17:0] ov;
    logic        rdy;
    logic [5:0]  op;
  } cyc_t;

  cyc_t  q[$];
  string scen;

  task automatic push(input logic [3:0] st, input logic [17:0] ov, input logic rdy,
                      input logic [5:0] op);
    cyc_t c;
    c.st = st; c.ov = ov; c.rdy = rdy; c.op = op;
    q.push_back(c);
  endtask

  // Expected trace of one instruction; fst/mst are wait cycles in fetch/memory.
  task automatic build_instr(input logic [5:0] op, input int fst, input int mst);
    logic [5:0] fop;
    for (int i = 0; i < fst; i++) begin
      fop = 6'($urandom);
      push(4'd0, MR | SB01, 1'b0, fop);
    end
    fop = 6'($urandom);
    push(4'd0, MR | SB01 | IRW | PCW, 1'b1, fop);
    case (op)
      6'b100011: begin
        push(4'd1, SB11, 1'($urandom), op);
        push(4'd2, SA | SB10, 1'($urandom), op);
        for (int i = 0; i < mst; i++) push(4'd3, MR | IORD, 1'b0, op);
        push(4'd3, MR | IORD, 1'b1, op);
        push(4'd4, RW | MTR | DONE, 1'($urandom), op);
      end
      6'b101011: begin
        push(4'd1, SB11, 1'($urandom), op);
        push(4'd2, SA | SB10, 1'($urandom), op);
        for (int i = 0; i < mst; i++) push(4'd5, MW | IORD, 1'b0, op);
        push(4'd5, MW | IORD | DONE, 1'b1, op);
      end
      6'b000000: begin
        push(4'd1, SB11, 1'($urandom), op);
        push(4'd6, SA | AO10, 1'($urandom), op);
        push(4'd7, RW | RD | DONE, 1'($urandom), op);
      end
      6'b000100: begin
        push(4'd1, SB11, 1'($urandom), op);
        push(4'd8, SA | AO01 | PC01 | BR | DONE, 1'($urandom), op);
      end
      6'b001000: begin
        push(4'd1, SB11, 1'($urandom), op);
        push(4'd9, SA | SB10, 1'($urandom), op);
        push(4'd10, RW | DONE, 1'($urandom), op);
      end
      6'b000010: begin
        push(4'd1, SB11, 1'($urandom), op);
        push(4'd11, PC10 | PCW | DONE, 1'($urandom), op);
      end
      default: push(4'd1, SB11 | ILL, 1'($urandom), op);
    endcase
  endtask

  task automatic test_reset();
    scen = "reset";
    reset_n = 1'b0; mem_ready = 1'b0; opcode = 6'b100011;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", state);
    end
    n_checks++;
    if (outv !== (MR | SB01)) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", outv, MR | SB01);
    end
    mem_ready = 1'b1; #1;
    n_checks++;
    if (outv !== (MR | SB01 | IRW | PCW)) begin
      n_fail++; $display("FAIL reset_rdy_outputs: got %h expected %h", outv, MR | SB01 | IRW | PCW);
    end
    @(posedge clk); #1;
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL reset_held: got %0d expected 0", state);
    end
    @(negedge clk); reset_n = 1'b1; #1;
    @(posedge clk); #1;
    n_checks++;
    if (state !== 4'd1) begin
      n_fail++; $display("FAIL reset_first_fetch: got %0d expected 1", state);
    end
    @(negedge clk); opcode = 6'b111111; #1;
    n_checks++;
    if (outv !== (SB11 | ILL)) begin
      n_fail++; $display("FAIL reset_decode_illegal: got %h expected %h", outv, SB11 | ILL);
    end
  endtask

  task automatic test_directed();
    cyc_t c;
    int   cyc = 0;
    scen = "directed";
    build_instr(6'b100011, 0, 0);
    build_instr(6'b101011, 0, 2);
    build_instr(6'b000000, 0, 0);
    build_instr(6'b000100, 0, 0);
    build_instr(6'b000010, 0, 0);
    build_instr(6'b001000, 0, 0);
    build_instr(6'b111111, 0, 0);
    build_instr(6'b100011, 1, 1);
    build_instr(6'b000100, 2, 0);
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk); mem_ready = c.rdy; opcode = c.op; #1;
      n_checks++;
      if (state !== c.st) begin
        n_fail++; $display("FAIL %s_state cyc%0d: got %0d expected %0d", scen, cyc, state, c.st);
      end
      n_checks++;
      if (outv !== c.ov) begin
        n_fail++; $display("FAIL %s_outputs cyc%0d st%0d: got %h expected %h", scen, cyc, c.st,
                           outv, c.ov);
      end
      cyc++;
    end
  endtask

  task automatic test_reset_mid();
    cyc_t c;
    scen = "reset_mid";
    push(4'd0, MR | SB01 | IRW | PCW, 1'b1, 6'b000000);
    push(4'd1, SB11, 1'b1, 6'b100011);
    push(4'd2, SA | SB10, 1'b1, 6'b100011);
    push(4'd3, MR | IORD, 1'b0, 6'b100011);
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk); mem_ready = c.rdy; opcode = c.op; #1;
      n_checks++;
      if (state !== c.st) begin
        n_fail++; $display("FAIL %s_state: got %0d expected %0d", scen, state, c.st);
      end
    end
    #1; reset_n = 1'b0; #1;
    n_checks++;
    if (state !== 4'd0 || memwrite !== 1'b0 || regwrite !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_abort: got state %0d mw %b rw %b expected 0 0 0",
                         state, memwrite, regwrite);
    end
    n_checks++;
    if (outv !== (MR | SB01)) begin
      n_fail++; $display("FAIL reset_mid_outputs: got %h expected %h", outv, MR | SB01);
    end
    @(negedge clk); mem_ready = 1'b0; reset_n = 1'b1;
  endtask

  task automatic test_random();
    cyc_t       c;
    int         cyc = 0;
    logic [5:0] op;
    logic [5:0] legal[6];
    scen = "random";
    legal = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 6) == 0) begin
        op = 6'($urandom);
        if (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})
          op = 6'b111111;
      end else begin
        op = legal[$urandom_range(0, 5)];
      end
      build_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk); mem_ready = c.rdy; opcode = c.op; #1;
      n_checks++;
      if (state !== c.st) begin
        n_fail++; $display("FAIL %s_state cyc%0d: got %0d expected %0d", scen, cyc, state, c.st);
      end
      n_checks++;
      if (outv !== c.ov) begin
        n_fail++; $display("FAIL %s_outputs cyc%0d st%0d: got %h expected %h", scen, cyc, c.st,
                           outv, c.ov);
      end
      cyc++;
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL random_final_fetch: got %0d expected 0", state);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences the multicycle MIPS datapath: shared memory for instruction and data, a single ALU, instruction register, PC.
- Replaces the single-cycle opcode decoder for the multicycle core. Consumes the IR opcode and a memory-ready handshake; drives every datapath enable and mux select.
- Supports R-type, lw, sw, beq, addi, j. Any other opcode is flagged and skipped.

Parameters:
MEM_WAIT_EN  1  1: honour mem_ready stalls; 0: mem_ready internally forced to 1

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
opcode  input  6  instr[31:26] from IR; stable from DECODE until next FETCH
mem_ready  input  1  memory completes the current read/write this cycle
memread  output  1  memory read strobe
memwrite  output  1  memory write strobe
iord  output  1  address mux: 0=PC, 1=ALUOut
irwrite  output  1  load IR
pcwrite  output  1  unconditional PC write
branch  output  1  PC write if ALU zero
pcsrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
alusrca  output  1  0=PC, 1=regA
alusrcb  output  2  00=regB, 01=4, 10=signimm, 11=signimm<<2
aluop  output  2  to ALU decoder: 00=add, 01=sub, 10=funct
regdst  output  1  0=rt, 1=rd
memtoreg  output  1  0=ALUOut, 1=data register
regwrite  output  1  register file write
instr_done  output  1  one-cycle pulse on the final cycle of each instruction
illegal  output  1  one-cycle pulse in DECODE for an unsupported opcode
state  output  4  current state encoding, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable; if entered, go to FETCH with all outputs 0.
- reset_n low: state is forced to FETCH immediately (asynchronously). Outputs take the FETCH decode: memread=1, alusrcb=01, all others 0. irwrite and pcwrite follow mem_ready. Reset mid-instruction aborts it, with no pending strobes.
- Outputs are combinational from state, plus mem_ready gating where stated. Every output not listed for a state is 0; no X values in any state.
  - FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00, irwrite=pcwrite=mem_ready.
  - DECODE: alusrca=0, alusrcb=11, aluop=00; illegal=1 if opcode is unsupported.
  - MEMADR, ADDIEXEC: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: memread=1, iord=1.
  - MEMWB: regwrite=1, memtoreg=1, regdst=0, instr_done=1.
  - MEMWR: memwrite=1, iord=1, instr_done=mem_ready.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10.
  - ALUWB: regwrite=1, regdst=1, memtoreg=0, instr_done=1.
  - BRANCH: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1, instr_done=1.
  - ADDIWB: regwrite=1, regdst=0, memtoreg=0, instr_done=1.
  - JUMP: pcsrc=10, pcwrite=1, instr_done=1.
- Transitions (registered on the rising edge):
  - FETCH -> DECODE if mem_ready, else stay.
  - DECODE by opcode:
    - 100011 or 101011 -> MEMADR
    - 000000 -> EXECUTE
    - 000100 -> BRANCH
    - 001000 -> ADDIEXEC
    - 000010 -> JUMP
    - else -> FETCH
  - MEMADR -> MEMRD if opcode=100011, else MEMWR.
  - MEMRD -> MEMWB if mem_ready, else stay.
  - MEMWR -> FETCH if mem_ready, else stay; memwrite is held high throughout.
  - EXECUTE -> ALUWB; ADDIEXEC -> ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
- Latency with mem_ready=1: lw 5 cycles, sw/R/addi 4, beq/j 3. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Stalls: no strobe other than memread/memwrite is asserted while waiting; PC and IR are not written until the ready cycle.
- Illegal opcode: 2-cycle sequence (FETCH, DECODE) with no register, memory or PC side effect beyond the FETCH PC+4.

Test Plan:
- Reset: hold reset_n=0 in an arbitrary state, release -> state=0, memread=1, alusrcb=01, regwrite=memwrite=0; first edge with mem_ready=1 -> state=1.
- lw (opcode 100011), mem_ready=1 -> state sequence 0,1,2,3,4,0. MEMRD shows iord=1, memread=1. MEMWB shows regwrite=1, memtoreg=1, instr_done=1.
- sw with mem_ready low for 2 cycles in MEMWR -> memwrite high for 3 cycles; instr_done only on the third; then FETCH.
- R-type 000000 then beq 000100 -> R: 0,1,6,7 with aluop=10 in EXECUTE and regdst=1 in ALUWB. beq: 0,1,8 with aluop=01, pcsrc=01, branch=1.
- j (000010), then addi (001000) -> j: 0,1,11 with pcwrite=1, pcsrc=10. addi: 0,1,9,10 with alusrcb=10 then regwrite=1, regdst=0.
- Opcode 111111 -> illegal=1 for one cycle in DECODE, next state FETCH, no regwrite/memwrite pulse. Reset asserted during MEMRD stall -> state=0 immediately with memwrite=0.
